// File: rtl/burst_fetch_unit_if.sv
// Sysbus request/response channel plus the decode-side fetch handshake and
// the redirect/end-of-program sideband of the burst fetch unit.
interface burst_fetch_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      instr_valid;
  logic                      instr_ready;
  logic [BUS_DATA_WIDTH-1:0] instr_data;
  logic [63:0]               instr_pc;
  logic                      redirect_valid;
  logic [63:0]               redirect_pc;
  logic                      end_of_program;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output instr_valid, instr_data, instr_pc, end_of_program,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  instr_valid, instr_data, instr_pc, end_of_program,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/burst_fetch_unit.sv
// Line-burst instruction fetcher: issues one Sysbus read per line, buffers the
// beats with their PCs, and handles PC redirect and zero-word end of program.
module burst_fetch_unit #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       LINE_BEATS     = 8,
  parameter int                       FIFO_DEPTH     = 16,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        entry,
  burst_fetch_unit_if.master bus
);
  localparam int LINE_BYTES = LINE_BEATS * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BEAT_W     = $clog2(LINE_BEATS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t                    state_r, state_s;
  logic [63:0]               fetch_pc_r, req_addr_r;
  logic                      halted_r, discard_r;
  logic [BEAT_W-1:0]         beat_r;
  logic [BUS_DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [63:0]               pc_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]          count_r;

  logic [63:0]       line_addr_s, beat_pc_s;
  logic [BEAT_W-1:0] skip_s;
  logic              start_s, beat_s, last_beat_s, eligible_s;
  logic              push_s, zero_s, pop_s, empty_s;
  logic              unused_s;

  assign line_addr_s = {fetch_pc_r[63:OFF_W], {OFF_W{1'b0}}};
  assign skip_s      = fetch_pc_r[OFF_W-1:3];
  // The request address is latched so a redirect can never alter a pending request.
  assign beat_pc_s   = req_addr_r + {{(64-OFF_W){1'b0}}, beat_r, 3'b000};

  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign start_s     = !halted_r && !bus.redirect_valid &&
                       ((CNT_W'(FIFO_DEPTH) - count_r) >= CNT_W'(LINE_BEATS));
  assign beat_s      = (state_r == RESP) && bus.bus_respcyc;
  assign last_beat_s = beat_s && (beat_r == BEAT_W'(LINE_BEATS - 1));
  assign eligible_s  = beat_s && (beat_r >= skip_s) && !discard_r && !halted_r &&
                       !bus.redirect_valid;
  assign push_s      = eligible_s && (|bus.bus_resp);
  assign zero_s      = eligible_s && !(|bus.bus_resp);
  assign pop_s       = bus.instr_valid && bus.instr_ready;

  assign bus.bus_reqcyc     = (state_r == REQ);
  assign bus.bus_req        = (state_r == REQ) ? BUS_DATA_WIDTH'(req_addr_r)
                                               : {BUS_DATA_WIDTH{1'b0}};
  assign bus.bus_reqtag     = (state_r == REQ) ? READ_TAG : {BUS_TAG_WIDTH{1'b0}};
  assign bus.bus_respack    = bus.bus_respcyc;
  assign bus.instr_valid    = !empty_s && !bus.redirect_valid;
  assign bus.instr_data     = data_mem_r[rd_ptr_r];
  assign bus.instr_pc       = pc_mem_r[rd_ptr_r];
  assign bus.end_of_program = halted_r && empty_s;
  assign unused_s           = ^{fetch_pc_r[2:0], bus.bus_resptag};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_s)        state_s = REQ;  else state_s = IDLE;
      REQ:     if (bus.bus_reqack) state_s = RESP; else state_s = REQ;
      RESP:    if (last_beat_s)    state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // Fetch PC, burst bookkeeping, halt and discard flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r <= entry;
      req_addr_r <= 64'd0;
      halted_r   <= 1'b0;
      discard_r  <= 1'b0;
      beat_r     <= {BEAT_W{1'b0}};
    end else begin
      if ((state_r == IDLE) && start_s) req_addr_r <= line_addr_s;
      // A discarded burst must not advance the PC set by its redirect.
      if (bus.redirect_valid)              fetch_pc_r <= bus.redirect_pc;
      else if (last_beat_s && !discard_r)  fetch_pc_r <= req_addr_r + 64'(LINE_BYTES);
      if (zero_s) halted_r <= 1'b1;
      if (last_beat_s)                                  discard_r <= 1'b0;
      else if (bus.redirect_valid && (state_r != IDLE)) discard_r <= 1'b1;
      if (beat_s) beat_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
    end
  end

  // Fetch buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (!reset || bus.redirect_valid) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Fetch buffer storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= bus.bus_resp;
      pc_mem_r[wr_ptr_r]   <= beat_pc_s;
    end
  end
endmodule

// File: tb/tb_burst_fetch_unit.sv
// Scoreboard bench for burst_fetch_unit: a scripted Sysbus memory drives bursts
// and a monitor compares every delivered word against the expected queue.
module tb_burst_fetch_unit;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int LB = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = 64'h1000;

  burst_fetch_unit_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

  burst_fetch_unit #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB), .FIFO_DEPTH(FD),
    .READ_TAG(13'h1100)
  ) dut (.clk(clk), .reset(reset), .entry(entry), .bus(bif));

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] pc; logic [63:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  bit   halted_m = 1'b0;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {32'hC0FF_EE00 ^ a[63:32], a[31:0] ^ 32'h5A5A_0001};
  endfunction

  // Delivered-word monitor: every pop must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && bif.instr_valid === 1'b1 && bif.instr_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word: got pc=%h data=%h, required no delivery",
                 bif.instr_pc, bif.instr_data);
      end else begin
        e = exp_q.pop_front();
        if (bif.instr_pc !== e.pc || bif.instr_data !== e.data)
          $display("FAIL word: got pc=%h data=%h, required pc=%h data=%h",
                   bif.instr_pc, bif.instr_data, e.pc, e.data);
        else passed++;
      end
    end
  end

  task automatic apply_reset(input logic [63:0] ent);
    @(posedge clk); #1;
    reset = 1'b0; entry = ent;
    bif.instr_ready = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_reqack = 1'b0;
    bif.redirect_valid = 1'b0;
    exp_q.delete(); halted_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Memory side of one burst: wait for the request, check it, ack and send beats.
  task automatic serve_burst(input logic [63:0] line, input int skip, input int zero_at,
                             input int redir_at, input logic [63:0] redir_pc,
                             input int ack_delay, input int stop_at);
    int n; bit discard; logic [63:0] pc; logic [63:0] w;
    n = 0; discard = 1'b0;
    do begin
      @(posedge clk); #1;
      bif.bus_respcyc = 1'b0; bif.bus_reqack = 1'b0; bif.redirect_valid = 1'b0;
      @(negedge clk); n++;
    end while (bif.bus_reqcyc !== 1'b1 && n < 300);
    checks++;
    if (bif.bus_reqcyc !== 1'b1) begin
      $display("FAIL req_timeout: bus_reqcyc=%b, required 1 for line %h", bif.bus_reqcyc, line);
      return;
    end
    if (bif.bus_req !== line || bif.bus_reqtag !== 13'h1100)
      $display("FAIL req_addr: bus_req=%h tag=%h, required %h tag 1100",
               bif.bus_req, bif.bus_reqtag, line);
    else passed++;
    for (int i = 0; i < ack_delay; i++) begin @(posedge clk); #1; @(negedge clk); end
    checks++;
    if (bif.bus_reqcyc !== 1'b1 || bif.bus_req !== line)
      $display("FAIL req_hold: reqcyc=%b req=%h, required 1 %h", bif.bus_reqcyc, bif.bus_req, line);
    else passed++;
    @(posedge clk); #1; bif.bus_reqack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; bif.bus_reqack = 1'b0;
    for (int k = 0; k < LB; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      if (k == stop_at) begin bif.bus_respcyc = 1'b0; bif.redirect_valid = 1'b0; return; end
      if (k == LB / 2) begin
        bif.bus_respcyc = 1'b0; bif.redirect_valid = 1'b0;
        @(posedge clk); #1;
      end
      pc = line + 64'(8 * k);
      w  = (k == zero_at) ? 64'd0 : mem_word(pc);
      bif.bus_respcyc = 1'b1; bif.bus_resp = w; bif.bus_resptag = 13'h00AA;
      if (k == redir_at) begin
        bif.redirect_valid = 1'b1; bif.redirect_pc = redir_pc; exp_q.delete();
      end else bif.redirect_valid = 1'b0;
      if (k >= skip && !discard && !halted_m && k != redir_at) begin
        if (w == 64'd0) halted_m = 1'b1;
        else exp_q.push_back({pc, w});
      end
      if (k == redir_at) discard = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.bus_respack !== 1'b1 || bif.bus_reqcyc !== 1'b0)
        $display("FAIL beat_ack: respack=%b reqcyc=%b at beat %0d, required 1 0",
                 bif.bus_respack, bif.bus_reqcyc, k);
      else passed++;
      if (redir_at >= 0 && (k == redir_at || k == redir_at + 1)) begin
        checks++;
        if (bif.instr_valid !== 1'b0)
          $display("FAIL redirect_valid_low: instr_valid=%b at beat %0d, required 0", bif.instr_valid, k);
        else passed++;
      end
    end
    @(posedge clk); #1;
    bif.bus_respcyc = 1'b0; bif.redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain_%s: %0d words outstanding, required 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bif.bus_reqcyc !== 1'b0 || bif.bus_req !== 64'd0 || bif.bus_reqtag !== 13'd0)
      $display("FAIL reset_req: reqcyc=%b req=%h tag=%h, required 0 0 0",
               bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag);
    else passed++;
    checks++;
    if (bif.bus_respack !== 1'b0 || bif.instr_valid !== 1'b0 || bif.end_of_program !== 1'b0)
      $display("FAIL reset_out: respack=%b valid=%b eop=%b, required 0 0 0",
               bif.bus_respack, bif.instr_valid, bif.end_of_program);
    else passed++;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_aligned();
    bif.instr_ready = 1'b1;
    serve_burst(64'h1000, 0, -1, -1, 64'd0, 3, LB);
    serve_burst(64'h1040, 0, -1, -1, 64'd0, 0, LB);
    wait_drain("aligned");
  endtask

  task automatic test_unaligned();
    apply_reset(64'h1010);
    bif.instr_ready = 1'b1;
    serve_burst(64'h1000, 2, -1, -1, 64'd0, 1, LB);
    wait_drain("unaligned");
  endtask

  task automatic test_backpressure();
    bit seen;
    apply_reset(64'h5000);
    serve_burst(64'h5000, 0, -1, -1, 64'd0, 0, LB);
    serve_burst(64'h5040, 0, -1, -1, 64'd0, 0, LB);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bif.bus_reqcyc !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) $display("FAIL bp_no_req: bus_reqcyc rose with 16 entries, required 0");
    else passed++;
    checks++;
    if (bif.instr_valid !== 1'b1 || bif.instr_pc !== 64'h5000)
      $display("FAIL bp_head: valid=%b pc=%h, required 1 0000000000005000", bif.instr_valid, bif.instr_pc);
    else passed++;
    @(posedge clk); #1 bif.instr_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 bif.instr_ready = 1'b0;
    serve_burst(64'h5080, 0, -1, -1, 64'd0, 0, LB);
    bif.instr_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_redirect();
    apply_reset(64'h1000);
    bif.instr_ready = 1'b1;
    serve_burst(64'h1000, 0, -1, 3, 64'h2008, 2, LB);
    serve_burst(64'h2000, 1, -1, -1, 64'd0, 0, LB);
    wait_drain("redirect");
  endtask

  task automatic test_eop();
    bit seen;
    apply_reset(64'h3000);
    bif.instr_ready = 1'b1;
    serve_burst(64'h3000, 0, 5, -1, 64'd0, 1, LB);
    wait_drain("eop");
    repeat (2) @(negedge clk);
    checks++;
    if (bif.end_of_program !== 1'b1)
      $display("FAIL eop_high: end_of_program=%b, required 1", bif.end_of_program);
    else passed++;
    seen = 1'b0;
    repeat (200) begin @(negedge clk); if (bif.bus_reqcyc !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen || bif.end_of_program !== 1'b1)
      $display("FAIL eop_quiet: req_seen=%b eop=%b, required 0 1", seen, bif.end_of_program);
    else passed++;
  endtask

  task automatic test_reset_midburst();
    apply_reset(64'h1000);
    bif.instr_ready = 1'b1;
    serve_burst(64'h1000, 0, -1, -1, 64'd0, 0, 3);
    reset = 1'b0; entry = 64'h4000; bif.instr_ready = 1'b0;
    exp_q.delete(); halted_m = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bif.bus_reqcyc !== 1'b0 || bif.bus_req !== 64'd0 || bif.bus_reqtag !== 13'd0 ||
        bif.bus_respack !== 1'b0 || bif.instr_valid !== 1'b0 || bif.end_of_program !== 1'b0)
      $display("FAIL midreset_out: reqcyc=%b req=%h tag=%h respack=%b valid=%b eop=%b, required all 0",
               bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag, bif.bus_respack,
               bif.instr_valid, bif.end_of_program);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1; bif.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.bus_respcyc = 1'b1; bif.bus_resp = mem_word(64'h1018 + 64'(8 * i));
      @(negedge clk);
      checks++;
      if (bif.bus_respack !== 1'b1 || bif.instr_valid !== 1'b0)
        $display("FAIL stray_beat: respack=%b valid=%b, required 1 0", bif.bus_respack, bif.instr_valid);
      else passed++;
      @(posedge clk); #1;
    end
    bif.bus_respcyc = 1'b0;
    serve_burst(64'h4000, 0, -1, -1, 64'd0, 0, LB);
    wait_drain("midreset");
  endtask

  initial begin
    bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_resp = 64'd0;
    bif.bus_resptag = 13'd0; bif.instr_ready = 1'b0; bif.redirect_valid = 1'b0;
    bif.redirect_pc = 64'd0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_backpressure();
    test_redirect();
    test_eop();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
